// File: rtl/sensor_frame_tx_pkg.sv
// Shared constants and state encodings for the sensor frame transmit path.
package roberto_pkg;

  localparam logic [2:0] ASC_ZERO_PREFIX = 3'b011;
  localparam logic [6:0] ASC_HASH        = 7'h23;
  localparam logic [6:0] ASC_QMARK       = 7'h3F;
  localparam logic [6:0] ASC_LF          = 7'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    CKSUM = 3'd4
  } sensor_frame_state_t;

  // Kind of byte currently held on tx_dados
  typedef enum logic [1:0] {
    SLOT_DIG = 2'd0,
    SLOT_SEP = 2'd1,
    SLOT_CK  = 2'd2,
    SLOT_END = 2'd3
  } slot_t;

endpackage

// File: rtl/sensor_frame_tx_bcd_ascii_enc.sv
// BCD nibble to ASCII digit; non-BCD nibbles become '?'.
module bcd_ascii_enc
  import roberto_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] asc_o
);

  always_comb asc_o = (nib_i > 4'd9) ? ASC_QMARK : {ASC_ZERO_PREFIX, nib_i};

endmodule

// File: rtl/sensor_frame_tx.sv
// Snapshots N_CH BCD measurements and streams them as one ASCII frame to a 7E1 tx.
// Define SENSOR_FRAME_CKSUM_EN to append an XOR checksum byte before END_CHAR.
module sensor_frame_tx
  import roberto_pkg::*;
#(
  parameter int         N_CH          = 3,
  parameter int         N_DIG         = 3,
  parameter logic [6:0] SEP_CHAR      = ASC_HASH,
  parameter int         END_EN        = 1,
  parameter logic [6:0] END_CHAR      = ASC_LF,
  parameter int         PERIOD_CYCLES = 1_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    periodic_en,
  input  logic [N_CH*4*N_DIG-1:0] medidas,
  output logic                    tx_partida,
  output logic [6:0]              tx_dados,
  input  logic                    tx_pronto,
  output logic                    busy,
  output logic                    frame_done,
  output logic [2:0]              db_estado,
  output logic [2:0]              db_canal,
  output logic [1:0]              db_digito
);

  localparam int MW = N_CH*4*N_DIG;
  localparam int IW = $clog2(MW);
  localparam int TW = $clog2(PERIOD_CYCLES);
`ifdef SENSOR_FRAME_CKSUM_EN
  localparam bit CK_EN = 1'b1;
  logic [6:0] cks_q;
`else
  localparam bit CK_EN = 1'b0;
`endif

  sensor_frame_state_t state_q;
  slot_t               slot_q, slot_d;
  logic [MW-1:0]       snap_q;
  logic [2:0]          ch_q, ch_d;
  logic [1:0]          dig_q, dig_d;
  logic [TW-1:0]       tmr_q;
  logic [6:0]          dados_q, byte_d, asc;
  logic [3:0]          nib;
  logic [IW-1:0]       idx;
  logic                pend_q, part_q, busy_q, done_q, last_d, tick;

  assign tick = periodic_en && (tmr_q == TW'(PERIOD_CYCLES-1));

  // Position of the byte that follows the one on the line
  always_comb begin
    slot_d = slot_q;
    ch_d   = ch_q;
    dig_d  = dig_q;
    last_d = 1'b0;
    case (slot_q)
      SLOT_DIG: if (dig_q == 2'(N_DIG-1)) slot_d = SLOT_SEP;
                else dig_d = dig_q + 2'd1;
      SLOT_SEP: if (ch_q == 3'(N_CH-1)) begin
                  if (CK_EN)            slot_d = SLOT_CK;
                  else if (END_EN != 0) slot_d = SLOT_END;
                  else                  last_d = 1'b1;
                end else begin
                  ch_d   = ch_q + 3'd1;
                  dig_d  = 2'd0;
                  slot_d = SLOT_DIG;
                end
      SLOT_CK:  if (END_EN != 0) slot_d = SLOT_END;
                else last_d = 1'b1;
      default:  last_d = 1'b1;
    endcase
  end

  // In IDLE the first digit comes straight from the live input, since the snapshot loads on the same edge
  always_comb begin
    idx = IW'(int'(ch_d)*4*N_DIG + (N_DIG-1-int'(dig_d))*4);
    nib = (state_q == IDLE) ? medidas[4*N_DIG-1 -: 4] : snap_q[idx +: 4];
  end

  bcd_ascii_enc u_enc (.nib_i(nib), .asc_o(asc));

  always_comb begin
    byte_d = asc;
    case (slot_d)
      SLOT_SEP: byte_d = SEP_CHAR;
`ifdef SENSOR_FRAME_CKSUM_EN
      SLOT_CK:  byte_d = cks_q ^ dados_q;
`else
      SLOT_CK:  byte_d = 7'h00;
`endif
      SLOT_END: byte_d = END_CHAR;
      default:  byte_d = asc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= SLOT_DIG;
      snap_q  <= '0;
      ch_q    <= '0;
      dig_q   <= '0;
      tmr_q   <= '0;
      dados_q <= '0;
      pend_q  <= 1'b0;
      part_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SENSOR_FRAME_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      part_q <= 1'b0;
      done_q <= 1'b0;
      if (!periodic_en || tick) tmr_q <= '0;
      else                      tmr_q <= tmr_q + 1'b1;
      if (tick && state_q != IDLE) pend_q <= 1'b1;
      case (state_q)
        IDLE: if (start || pend_q || tick) begin
          snap_q  <= medidas;
          ch_q    <= '0;
          dig_q   <= '0;
          slot_q  <= SLOT_DIG;
          pend_q  <= 1'b0;
          dados_q <= asc;
          part_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= SEND;
`ifdef SENSOR_FRAME_CKSUM_EN
          cks_q   <= '0;
`endif
        end
        SEND, CKSUM: state_q <= WAIT;
        WAIT: if (tx_pronto) begin
          if (last_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            ch_q    <= ch_d;
            dig_q   <= dig_d;
            slot_q  <= slot_d;
            dados_q <= byte_d;
            part_q  <= 1'b1;
            state_q <= (slot_d == SLOT_CK) ? CKSUM : SEND;
          end
`ifdef SENSOR_FRAME_CKSUM_EN
          cks_q <= cks_q ^ dados_q;
`endif
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_partida = part_q;
  assign tx_dados   = dados_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign db_estado  = state_q;
  assign db_canal   = ch_q;
  assign db_digito  = dig_q;

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Bench for sensor_frame_tx: two configurations driven by one directed sequence with a tx responder model.
module tb_sensor_frame_tx;

  typedef struct {int d; int k; int cyc; logic [6:0] b;} ev_t; // k: 0 partida, 1 done, 2 pronto

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] med;
  logic        st[2], pen[2], pr[2], stray[2];
  logic        part_w[2], busy_w[2], done_w[2];
  logic [6:0]  dados_w[2];
  logic [2:0]  est_w[2], can_w[2];
  logic [1:0]  dig_w[2];
  int          cnt[2], dly[2], ndone[2];
  int          cyc, tests, fails;
  ev_t         ev_q[$];
  logic [6:0]  exp_q[$];
  int          fs_q[$], ds_q[$];

  always #5 clk = ~clk;

  sensor_frame_tx #(.PERIOD_CYCLES(50)) u_a (
    .clock(clk), .reset(rst), .start(st[0]), .periodic_en(pen[0]), .medidas(med),
    .tx_partida(part_w[0]), .tx_dados(dados_w[0]), .tx_pronto(pr[0]), .busy(busy_w[0]),
    .frame_done(done_w[0]), .db_estado(est_w[0]), .db_canal(can_w[0]), .db_digito(dig_w[0]));

  sensor_frame_tx #(.N_CH(1), .N_DIG(2), .END_EN(0), .PERIOD_CYCLES(50)) u_b (
    .clock(clk), .reset(rst), .start(st[1]), .periodic_en(pen[1]), .medidas(med[7:0]),
    .tx_partida(part_w[1]), .tx_dados(dados_w[1]), .tx_pronto(pr[1]), .busy(busy_w[1]),
    .frame_done(done_w[1]), .db_estado(est_w[1]), .db_canal(can_w[1]), .db_digito(dig_w[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, responder acks dly cycles after each partida
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      pr[d] = 1'b0;
      if (part_w[d]) begin
        ev_q.push_back('{d, 0, cyc, dados_w[d]});
        cnt[d] = dly[d];
      end else if (cnt[d] > 0) begin
        cnt[d]--;
        if (cnt[d] == 0) begin
          pr[d] = 1'b1;
          ev_q.push_back('{d, 2, cyc, 7'h00});
        end
      end
      if (stray[d]) begin
        pr[d]    = 1'b1;
        stray[d] = 1'b0;
      end
      if (done_w[d]) begin
        ev_q.push_back('{d, 1, cyc, 7'h00});
        ndone[d]++;
      end
    end
  endtask

  // Reference frame from the byte-order rules
  task automatic build_exp(input logic [35:0] m, input int nch, input int ndig, input int endf);
    logic [6:0] cs;
    int         nb;
    exp_q.delete();
    cs = 7'h00;
    for (int c = 0; c < nch; c++) begin
      for (int k = 0; k < ndig; k++) begin
        nb = int'((m >> (c*4*ndig + (ndig-1-k)*4)) & 36'hF);
        exp_q.push_back(nb <= 9 ? 7'(8'h30 + nb) : 7'h3F);
        cs ^= exp_q[exp_q.size()-1];
      end
      exp_q.push_back(7'h23);
      cs ^= 7'h23;
    end
`ifdef SENSOR_FRAME_CKSUM_EN
    exp_q.push_back(cs);
`endif
    if (endf != 0) exp_q.push_back(7'h0A);
  endtask

  function automatic int n_ev(input int d, input int k);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].d == d && ev_q[i].k == k) n++;
    return n;
  endfunction

  task automatic run_done(input int d, input int budget, input string tag);
    int n0 = ndone[d];
    int n  = 0;
    while (ndone[d] == n0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 64'(ndone[d] != n0), 1);
    repeat (3) step();
  endtask

  task automatic check_frame(input int d, input string tag, input int nfr);
    logic [6:0] got[$];
    foreach (ev_q[i]) if (ev_q[i].d == d && ev_q[i].k == 0) got.push_back(ev_q[i].b);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()*nfr));
    for (int i = 0; i < got.size() && exp_q.size() > 0; i++)
      chk($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i % exp_q.size()]));
  endtask

  // Each partida or frame_done that follows an ack must come exactly one cycle later
  task automatic check_lat(input int d, input string tag);
    int  pc   = 0;
    bit  have = 1'b0;
    foreach (ev_q[i]) if (ev_q[i].d == d) begin
      if (ev_q[i].k == 2) begin
        pc   = ev_q[i].cyc;
        have = 1'b1;
      end else if (have) begin
        chk({tag, "_lat"}, 64'(ev_q[i].cyc - pc), 1);
        have = 1'b0;
      end
    end
  endtask

  task automatic get_starts(input int d);
    bit newf = 1'b1;
    fs_q.delete();
    ds_q.delete();
    foreach (ev_q[i]) if (ev_q[i].d == d) begin
      if (ev_q[i].k == 0 && newf) begin
        fs_q.push_back(ev_q[i].cyc);
        newf = 1'b0;
      end
      if (ev_q[i].k == 1) begin
        ds_q.push_back(ev_q[i].cyc);
        newf = 1'b1;
      end
    end
  endtask

  initial begin
    int n, off, fs1, after;
    tests = 0; fails = 0; cyc = 0;
    rst = 1'b0;
    med = '0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; pen[d] = 1'b0; pr[d] = 1'b0; stray[d] = 1'b0;
      cnt[d] = 0; ndone[d] = 0;
    end
    dly[0] = 20; dly[1] = 5;

    repeat (3) step();
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outs%0d", d),
          64'({part_w[d], busy_w[d], done_w[d], dados_w[d], est_w[d], can_w[d], dig_w[d]}), 0);
    rst = 1'b1;
    step();

    // Manual frame, with a start pulse mid-frame that must be ignored
    med = {12'h999, 12'h045, 12'h123};
    build_exp(med, 3, 3, 1);
    ev_q.delete();
    st[0] = 1'b1; step(); st[0] = 1'b0;
    chk("start_lat", 64'(part_w[0]), 1);
    step();
    chk("busy_in_frame", 64'(busy_w[0]), 1);
    repeat (30) step();
    st[0] = 1'b1; step(); st[0] = 1'b0;
    run_done(0, 1000, "manual");
    repeat (20) step();
    check_frame(0, "manual", 1);
    check_lat(0, "manual");
    chk("manual_ndone", 64'(n_ev(0, 1)), 1);
    chk("manual_idle", 64'({busy_w[0], est_w[0]}), 0);

    // Stray ack in IDLE, non-BCD digit, and input change after capture
    med = {12'h999, 12'h0A7, 12'h123};
    ev_q.delete();
    stray[0] = 1'b1;
    repeat (10) step();
    chk("stray_no_partida", 64'(n_ev(0, 0)), 0);
    build_exp(med, 3, 3, 1);
    st[0] = 1'b1; step(); st[0] = 1'b0;
    repeat (3) step();
    med = 36'h456_456_456;
    run_done(0, 1000, "nonbcd");
    check_frame(0, "nonbcd", 1);

    // Random measurements and ack delays
    for (int it = 0; it < 4; it++) begin
      med    = {4'($urandom), 32'($urandom)};
      dly[0] = int'($urandom_range(1, 6));
      build_exp(med, 3, 3, 1);
      ev_q.delete();
      st[0] = 1'b1; step(); st[0] = 1'b0;
      repeat (2) step();
      med = {4'($urandom), 32'($urandom)};
      run_done(0, 1000, $sformatf("rand%0d", it));
      check_frame(0, $sformatf("rand%0d", it), 1);
      check_lat(0, $sformatf("rand%0d", it));
    end

    // Reset while waiting on the ack of byte 5
    dly[0] = 20;
    med = {12'h999, 12'h045, 12'h123};
    build_exp(med, 3, 3, 1);
    ev_q.delete();
    st[0] = 1'b1; step(); st[0] = 1'b0;
    n = 0;
    while (!(n_ev(0, 0) == 5 && !part_w[0]) && n < 1000) begin
      step();
      n++;
    end
    chk("rst_mid_reach", 64'(n < 1000), 1);
    chk("rst_mid_state", 64'(est_w[0]), 2);
    rst = 1'b0; cnt[0] = 0;
    step();
    chk("rst_mid_outs", 64'({part_w[0], busy_w[0], done_w[0], dados_w[0], est_w[0], can_w[0], dig_w[0]}), 0);
    rst = 1'b1;
    ev_q.delete();
    repeat (40) step();
    chk("rst_mid_quiet", 64'(n_ev(0, 0)), 0);
    st[0] = 1'b1; step(); st[0] = 1'b0;
    run_done(0, 1000, "after_rst");
    check_frame(0, "after_rst", 1);

    // Overrun: frame longer than the period, pending is one deep
    dly[0] = 10;
    ev_q.delete();
    pen[0] = 1'b1;
    repeat (700) step();
    pen[0] = 1'b0;
    off = cyc;
    repeat (400) step();
    get_starts(0);
    chk("ovr_nframes", 64'(fs_q.size() >= 3), 1);
    chk("ovr_closed", 64'(fs_q.size()), 64'(ds_q.size()));
    for (int i = 1; i < fs_q.size() && i <= ds_q.size(); i++)
      chk($sformatf("ovr_gap%0d", i), 64'(fs_q[i] - ds_q[i-1]), 2);
    after = 0;
    foreach (fs_q[i]) if (fs_q[i] > off) after++;
    chk("ovr_pend_depth", 64'(after <= 1), 1);
    check_frame(0, "ovr", ds_q.size());

    // Periodic on the short configuration, with a start coinciding with one tick
    med[7:0] = 8'($urandom);
    build_exp(med, 1, 2, 0);
    ev_q.delete();
    pen[1] = 1'b1;
    fs1 = -1;
    for (int i = 0; i < 650; i++) begin
      st[1] = (fs1 >= 0 && cyc == fs1 + 149);
      step();
      if (fs1 < 0 && part_w[1]) fs1 = cyc;
    end
    st[1] = 1'b0;
    pen[1] = 1'b0;
    repeat (60) step();
    get_starts(1);
    chk("per_nframes", 64'(fs_q.size() >= 11), 1);
    for (int i = 1; i < fs_q.size(); i++)
      chk($sformatf("per_spacing%0d", i), 64'(fs_q[i] - fs_q[i-1]), 50);
    check_frame(1, "per", ds_q.size());
    check_lat(1, "per");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_frame_tx.md
Name: sensor_frame_tx

Overview:
Parametrised successor of the fixed three-sensor serial reporting path. Snapshots N_CH packed BCD distance measurements and streams them as one ASCII frame through the 7E1 transmitter handshake (partida/pronto). Supports manual or periodic triggering, non-BCD digit substitution and an optional frame end character. Sits between the hcsr04 interfaces and tx_serial_7E1, replacing the cascaded muxes and the 2-bit/3-bit index counters.

Parameters:
N_CH, 3, number of sensor channels (1..8)
N_DIG, 3, BCD digits per measurement, MSB digit sent first (1..4)
SEP_CHAR, 7'h23, separator sent after each channel's digits ('#')
END_EN, 1, 1 = append END_CHAR after the last separator; 0 = no end character
END_CHAR, 7'h0A, frame end character
PERIOD_CYCLES, 1_000_000, period of the auto-trigger timer in clock cycles (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  manual frame request; sampled only in IDLE
periodic_en  in  1  enables the auto-trigger timer
medidas  in  N_CH*4*N_DIG  packed BCD; channel c at bits [c*4*N_DIG +: 4*N_DIG]
tx_partida  out  1  one-cycle start pulse to the transmitter
tx_dados  out  7  ASCII byte to transmit
tx_pronto  in  1  transmitter done pulse
busy  out  1  high from frame capture until frame_done
frame_done  out  1  one-cycle pulse after the last byte is acknowledged
db_estado  out  3  FSM state encoding
db_canal  out  3  current channel index
db_digito  out  2  current digit index

Behaviour:
- Reset (reset==0 at an edge): state IDLE. tx_partida=0, tx_dados=0, busy=0, frame_done=0. Channel, digit and timer counters cleared; pending flag cleared. Reset mid-frame aborts the frame immediately; no further partida is issued.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: trigger = start | pending | tick. On a trigger: snapshot medidas into an internal register, clear indices, clear pending, go to SEND.
- SEND: tx_partida=1 for exactly one cycle, then go to WAIT.
- WAIT: hold tx_dados. On tx_pronto: if this is the last byte, go to DONE; otherwise advance the byte position and go to SEND.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Latency: trigger in cycle t gives tx_partida in cycle t+1. tx_pronto in cycle t gives the next tx_partida in cycle t+1. frame_done is asserted the cycle after the last tx_pronto.
- busy=1 in SEND, WAIT and DONE.
- tx_dados is registered and stable from SEND through the end of WAIT.
- Byte order per channel c=0..N_CH-1: N_DIG digits MSB first, then SEP_CHAR. If END_EN=1, END_CHAR follows the last channel's separator.
- Bytes per frame: N_CH*(N_DIG+1)+END_EN.
- Digit encoding: nibble 0..9 is sent as {3'b011,nibble}. Nibble >9 is sent as '?' (7'h3F).
- Byte sequencing: the digit index wraps at N_DIG; the separator slot then advances the channel index. The channel index wraps to 0 only on a new frame.
- Timer: counts while periodic_en=1 and holds at 0 while periodic_en=0. It produces a one-cycle tick at count PERIOD_CYCLES-1, then wraps to 0.
- A tick while busy sets pending, which is one-deep: further ticks are lost. The pending frame starts in the cycle after the return to IDLE.
- start while busy is ignored.
- tx_pronto outside WAIT is ignored.
- Changes on medidas after capture do not affect the frame in flight.
- start and tick in the same cycle produce exactly one frame.

Optional Feature:
Macro SENSOR_FRAME_CKSUM_EN.
- Defined: one extra byte is sent immediately before END_CHAR (or last, if END_EN=0). The byte is the 7-bit XOR of all preceding bytes in the frame. An FSM state CKSUM is added and the bytes-per-frame count rises by 1.
- Undefined: no checksum byte, no XOR accumulator logic.

Decomposition:
- Package roberto_pkg holds:
  - ASCII constants: ASC_ZERO_PREFIX=3'b011, ASC_HASH=7'h23, ASC_QMARK=7'h3F, ASC_LF=7'h0A.
  - State typedef sensor_frame_state_t: IDLE=0, SEND=1, WAIT=2, DONE=3, CKSUM=4.
- One sub-module: bcd_ascii_enc (4-bit nibble to 7-bit ASCII with '?' substitution), reused by the receive side.

Test Plan:
- Manual frame, N_CH=3, N_DIG=3, END_EN=1. medidas ch0=0x123, ch1=0x045, ch2=0x999; start pulse; tx model acks 20 cycles after each partida. Required: 13 bytes 31 32 33 23 30 34 35 23 39 39 39 23 0A in order, then one frame_done.
- Non-BCD: ch1=0x0A7. Required: bytes 30 3F 37 23 for ch1.
- Periodic: PERIOD_CYCLES=50, ack 5 cycles after partida, 12 frames' worth of time. Required: partida-to-partida spacing between frame starts exactly 50 cycles; no pending frames.
- Overrun: PERIOD_CYCLES=50, ack 10 cycles after partida (frame longer than period). Required: every frame starts the cycle after the previous DONE; extra ticks dropped; never two frames overlap.
- Reset mid-frame: drive reset=0 for 1 cycle in WAIT of byte 5. Required: all outputs 0 next cycle; a later start yields a complete fresh 13-byte frame.
- Snapshot/stray ack: change medidas during the frame and pulse tx_pronto in IDLE. Required: frame carries the captured values; the stray pronto causes no partida.
